// File: rtl/sram_loader_if.sv
// rtl/sram_loader_if.sv - byte receive stream and SRAM port-a write bus for sram_loader
// Signals:
//   rx_data    [7:0]             byte from the serial receiver
//   rx_valid                     rx_data is valid
//   rx_ready                     loader accepts a byte this cycle
//   addr_a     [ADDR_WIDTH-1:0]  SRAM port-a write address
//   wdata_a    [WIDTH-1:0]       SRAM port-a write data
//   write_en_a                   SRAM port-a write strobe
// Modports: master = loader side, slave = receiver/SRAM side.
interface sram_loader_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [WIDTH-1:0]      wdata_a;
  logic                  write_en_a;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, addr_a, wdata_a, write_en_a
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, addr_a, wdata_a, write_en_a
  );
endinterface

// File: rtl/sram_loader.sv
// rtl/sram_loader.sv - serial byte-stream loader that fills an SRAM over port a
// Stream format: 16-bit word count N (LSB first), then N words of WIDTH/8 bytes
// each, LSB first. Words are written to consecutive addresses from 0.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports:
//   i_clk    clock, all logic on rising edge
//   i_rst    synchronous active-high reset
//   i_start  single-cycle pulse that begins a load (honoured in IDLE/DONE only)
//   bus      sram_loader_if.master: rx byte stream in, SRAM write port out
//   o_busy   load in progress
//   o_done   load finished (level)
//   o_error  load failed (level), valid while o_done=1
module sram_loader #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  sram_loader_if.master bus,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_error
);

  localparam int BPW = WIDTH / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_CSUM   = 3'd5;
`endif
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]            r_state;
  logic [15:0]           r_len;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [BCW-1:0]        r_bcnt;
  logic [WIDTH-1:0]      r_shift;
  logic                  r_done;
  logic                  r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif

  logic                  w_accept;
  logic [15:0]           w_len_full;
  logic                  w_last_byte;
  logic                  w_more;
  logic [WIDTH-1:0]      w_shift_next;

  assign w_accept    = bus.rx_valid & bus.rx_ready;
  assign w_len_full  = {bus.rx_data, r_len[7:0]};
  assign w_last_byte = (r_bcnt == BCW'(BPW - 1));
  // Compared at 32 bits so the index is only advanced when another word follows;
  // this keeps r_idx <= DEPTH-1 even for N = DEPTH.
  assign w_more      = ((32'(r_idx) + 32'd1) < {16'd0, r_len});
  // New bytes enter at the top, so after BPW bytes the first one sits at bit 0.
  assign w_shift_next = (r_shift >> 8) | ({{(WIDTH-8){1'b0}}, bus.rx_data} << (WIDTH - 8));

`ifdef LOADER_CHECKSUM_EN
  assign bus.rx_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA)   || (r_state == S_CSUM);
`else
  assign bus.rx_ready = (r_state == S_LEN_LO) || (r_state == S_LEN_HI) ||
                        (r_state == S_DATA);
`endif

  assign bus.write_en_a = (r_state == S_WRITE);
  assign bus.addr_a     = r_idx;
  assign bus.wdata_a    = r_shift;
  assign o_busy         = (r_state != S_IDLE) && (r_state != S_DONE);
  assign o_done         = r_done;
  assign o_error        = r_error;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_shift <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state <= S_LEN_LO;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_idx   <= '0;
            r_bcnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_LEN_LO: begin
          if (w_accept) begin
            r_len[7:0] <= bus.rx_data;
            r_state    <= S_LEN_HI;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.rx_data;
`endif
          end
        end
        S_LEN_HI: begin
          if (w_accept) begin
            r_len <= w_len_full;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ bus.rx_data;
`endif
            if (32'(w_len_full) > 32'(DEPTH)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_error <= 1'b1;
            end else if (w_len_full == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
`else
              r_state <= S_DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              r_state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_shift <= w_shift_next;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ bus.rx_data;
`endif
            if (w_last_byte) begin
              r_bcnt  <= '0;
              r_state <= S_WRITE;
            end else begin
              r_bcnt <= r_bcnt + BCW'(1);
            end
          end
        end
        S_WRITE: begin
          if (w_more) begin
            r_idx   <= r_idx + ADDR_WIDTH'(1);
            r_state <= S_DATA;
          end else begin
`ifdef LOADER_CHECKSUM_EN
            r_state <= S_CSUM;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
`endif
          end
        end
`ifdef LOADER_CHECKSUM_EN
        S_CSUM: begin
          if (w_accept) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_error <= (bus.rx_data != r_csum);
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_loader.sv
// tb/tb_sram_loader.sv - self-checking scoreboard bench for sram_loader
module tb_sram_loader;
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, error;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic [7:0]  tb_xor;

  sram_loader_if #(.WIDTH(32), .ADDR_WIDTH(8)) bus ();

  sram_loader #(.WIDTH(32), .DEPTH(256), .ADDR_WIDTH(8)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .bus     (bus.master),
    .o_busy  (busy),
    .o_done  (done),
    .o_error (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.write_en_a === 1'b1) begin
      if (exp_addr_q.size() == 0) begin
        check("unexpected_write", 64'(bus.addr_a), 64'hFFFF);
      end else begin
        check("write_addr", 64'(bus.addr_a), 64'(exp_addr_q.pop_front()));
        check("write_data", 64'(bus.wdata_a), 64'(exp_data_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (bus.rx_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("rx_ready_timeout", 64'(bus.rx_ready), 64'd1);
    @(negedge clk);
    tb_xor = tb_xor ^ b;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    if (gap) begin
      check("busy_during_gap", 64'(busy), 64'd1);
      @(negedge clk);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("done_reached", 64'(done), 64'd1);
  endtask

  task automatic send_csum(input bit gap);
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] cs;
    cs = tb_xor;
    send_byte(cs, gap);
`else
    if (gap) @(negedge clk);
`endif
  endtask

  task automatic run_load(input int n, input logic [31:0] base, input logic [31:0] step, input bit gap);
    logic [31:0] w;
    logic [15:0] len;
    tb_xor = 8'h00;
    len = 16'(n);
    pulse_start();
    check("busy_after_start", 64'(busy), 64'd1);
    send_byte(len[7:0], gap);
    send_byte(len[15:8], gap);
    for (int i = 0; i < n; i++) begin
      w = base + 32'(i) * step;
      exp_addr_q.push_back(8'(i));
      exp_data_q.push_back(w);
      for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], gap);
    end
    send_csum(gap);
    wait_done();
    check("load_error", 64'(error), 64'd0);
    check("load_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    tb_xor = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("rst_write_en", 64'(bus.write_en_a), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_addr", 64'(bus.addr_a), 64'd0);
    check("rst_wdata", 64'(bus.wdata_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two-word reference load: 0x11223344 then 0x55667788.
    run_load(2, 32'h11223344, 32'h44444444, 1'b0);
    repeat (3) @(negedge clk);
    check("done_held", 64'(done), 64'd1);

    // Same one-word load with continuous and with alternating valid.
    run_load(1, 32'h0A0B0C0D, 32'h0, 1'b0);
    run_load(1, 32'h0A0B0C0D, 32'h0, 1'b1);

    // Reset after 3 of 4 data bytes, then a clean load of 0xCAFEF00D.
    tb_xor = 8'h00;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h0D, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'hFE, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("midrst_wdata", 64'(bus.wdata_a), 64'd0);
    repeat (3) @(negedge clk);
    run_load(1, 32'hCAFEF00D, 32'h0, 1'b0);

    // Start pulsed during DATA is ignored.
    tb_xor = 8'h00;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    pulse_start();
    check("start_in_data_busy", 64'(busy), 64'd1);
    check("start_in_data_ready", 64'(bus.rx_ready), 64'd1);
    exp_addr_q.push_back(8'd0);
    exp_data_q.push_back(32'h44332211);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_csum(1'b0);
    wait_done();
    check("ignored_start_error", 64'(error), 64'd0);

    // N = 257 exceeds DEPTH: immediate error, no writes.
    tb_xor = 8'h00;
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("ovf_rx_ready", 64'(bus.rx_ready), 64'd0);
    check("ovf_done", 64'(done), 64'd1);
    check("ovf_error", 64'(error), 64'd1);
    check("ovf_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("ovf_error_held", 64'(error), 64'd1);

    // Start in DONE clears done/error and enters LEN_LO; then an N = 0 load.
    tb_xor = 8'h00;
    pulse_start();
    check("restart_done", 64'(done), 64'd0);
    check("restart_error", 64'(error), 64'd0);
    check("restart_busy", 64'(busy), 64'd1);
    check("restart_rx_ready", 64'(bus.rx_ready), 64'd1);
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    send_csum(1'b0);
    wait_done();
    check("zero_len_error", 64'(error), 64'd0);

`ifdef LOADER_CHECKSUM_EN
    // XOR of 01 00 AA BB CC DD is 0x01: 0x00 must fail, 0x01 must pass.
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send_byte(8'h01, 1'b0);
      send_byte(8'h00, 1'b0);
      exp_addr_q.push_back(8'd0);
      exp_data_q.push_back(32'hDDCCBBAA);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      send_byte(8'hCC, 1'b0);
      send_byte(8'hDD, 1'b0);
      send_byte(8'(k), 1'b0);
      wait_done();
      check("csum_error", 64'(error), (k == 0) ? 64'd1 : 64'd0);
    end
`endif

    // N = DEPTH: last address 255, no wrap.
    run_load(256, 32'h03020100, 32'h04040404, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_addr_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
